// File: rtl/exc_pkg.sv
// Shared defaults and cause index constants for the exception flag register.
// The control unit uses the cause constants for EPC/vector selection.
package exc_pkg;

    localparam int EXC_N_CH    = 4;
    localparam int EXC_CNT_W   = 8;
    localparam int EXC_CAUSE_W = 4;

    typedef logic [EXC_CAUSE_W-1:0] exc_cause_t;

    localparam exc_cause_t CAUSE_OVERFLOW   = 4'd0;
    localparam exc_cause_t CAUSE_DIV0       = 4'd1;
    localparam exc_cause_t CAUSE_BAD_OPCODE = 4'd2;
    localparam exc_cause_t CAUSE_MISALIGN   = 4'd3;

endpackage

// File: rtl/flag_event_counter.sv
// Per-channel debug counter: counts rising edges of a qualified event and
// saturates at all-ones. A clear overrides any increment on the same edge.
module flag_event_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             q,
    input  logic             count_clr,
    output logic [CNT_W-1:0] count
);

    logic             q_prev_q, q_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise;

    always_comb begin
        q_prev_d = q;
        rise     = q & ~q_prev_q;
        cnt_d    = cnt_q;
        if (count_clr) begin
            cnt_d = '0;
        end else if (rise && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_prev_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            q_prev_q <= q_prev_d;
            cnt_q    <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/exception_flag_reg.sv
// Qualified exception flags with pass-through/sticky modes, lowest-index
// cause encoding with ack handshake, and per-channel saturating event counters.
module exception_flag_reg
    import exc_pkg::*;
#(
    parameter int N_CH    = EXC_N_CH,
    parameter int CNT_W   = EXC_CNT_W,
    parameter int CAUSE_W = EXC_CAUSE_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mode_sticky,
    input  logic [N_CH-1:0]       use_flag,
    input  logic [N_CH-1:0]       flag_in,
    input  logic [N_CH-1:0]       flag_clr,
    input  logic                  exc_ack,
    input  logic                  count_clr,
    output logic [N_CH-1:0]       flag_out,
    output logic                  exc_pending,
    output logic [CAUSE_W-1:0]    exc_cause,
    output logic [N_CH*CNT_W-1:0] event_count
);

    logic [N_CH-1:0]    flag_q, flag_d;
    logic [N_CH-1:0]    q;
    logic [N_CH-1:0]    ack_hit;
    logic [CAUSE_W-1:0] cause;

    // Cause and pending look only at the registered flags, never at inputs.
    always_comb begin
        cause = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (flag_q[i]) begin
                cause = CAUSE_W'(i);
            end
        end
    end

    assign exc_pending = |flag_q;
    assign exc_cause   = cause;
    assign flag_out    = flag_q;

    always_comb begin
        q       = use_flag & flag_in;
        ack_hit = '0;
        for (int i = 0; i < N_CH; i++) begin
            ack_hit[i] = exc_ack & exc_pending & (cause == CAUSE_W'(i));
        end
        // New events take precedence over clear/ack so no event is dropped.
        if (mode_sticky) begin
            flag_d = q | (flag_q & ~flag_clr & ~ack_hit);
        end else begin
            flag_d = q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flag_q <= '0;
        end else begin
            flag_q <= flag_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_cnt
        flag_event_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clock     (clock),
            .reset     (reset),
            .q         (q[g]),
            .count_clr (count_clr),
            .count     (event_count[g*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_exception_flag_reg.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run, all checked against a behavioural model every cycle.
module tb_exception_flag_reg;

    localparam int N  = 4;
    localparam int CW = 3;
    localparam int KW = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic            mode_sticky;
    logic [N-1:0]    use_flag, flag_in, flag_clr;
    logic            exc_ack, count_clr;
    logic [N-1:0]    flag_out;
    logic            exc_pending;
    logic [KW-1:0]   exc_cause;
    logic [N*CW-1:0] event_count;

    exception_flag_reg #(.N_CH(N), .CNT_W(CW), .CAUSE_W(KW)) dut (
        .clock       (clock),
        .reset       (reset),
        .mode_sticky (mode_sticky),
        .use_flag    (use_flag),
        .flag_in     (flag_in),
        .flag_clr    (flag_clr),
        .exc_ack     (exc_ack),
        .count_clr   (count_clr),
        .flag_out    (flag_out),
        .exc_pending (exc_pending),
        .exc_cause   (exc_cause),
        .event_count (event_count)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state
    bit [N-1:0] mf;
    bit [N-1:0] mprev;
    int         mcnt [N];

    function automatic int m_cause();
        for (int i = 0; i < N; i++) if (mf[i]) return i;
        return 0;
    endfunction

    function automatic logic [N*CW-1:0] m_counts();
        logic [N*CW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*CW +: CW] = mcnt[i][CW-1:0];
        return v;
    endfunction

    task automatic m_reset();
        mf    = '0;
        mprev = '0;
        for (int i = 0; i < N; i++) mcnt[i] = 0;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Advance one clock edge, updating the model from the inputs seen at that edge.
    task automatic step();
        bit [N-1:0] qv, nf;
        int         cz;
        bit         pend;
        qv   = use_flag & flag_in;
        pend = (mf != 0);
        cz   = m_cause();
        for (int i = 0; i < N; i++) begin
            if (!mode_sticky) nf[i] = qv[i];
            else nf[i] = qv[i] | (mf[i] & ~flag_clr[i] & ~(exc_ack & pend & (cz == i)));
        end
        @(posedge clock);
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                if (count_clr) mcnt[i] = 0;
                else if (qv[i] && !mprev[i] && mcnt[i] < (1 << CW) - 1) mcnt[i]++;
            end
            mprev = qv;
            mf    = nf;
        end
        #1;
    endtask

    always @(negedge clock) begin
        chk("flag_out", 64'(flag_out), 64'(mf));
        chk("exc_pending", 64'(exc_pending), 64'(mf != 0));
        chk("exc_cause", 64'(exc_cause), 64'(m_cause()));
        chk("event_count", 64'(event_count), 64'(m_counts()));
    end

    initial begin
        m_reset();
        reset = 1'b0;
        mode_sticky = 1'b0;
        use_flag = '0; flag_in = '0; flag_clr = '0;
        exc_ack = 1'b0; count_clr = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_flags", 64'(flag_out), 64'd0);
        chk("reset_cause", 64'(exc_cause), 64'd0);
        #3 reset = 1'b1;
        #1;

        // Pass-through
        use_flag = 4'b0001; flag_in = 4'b0011; step();
        chk("pass_first", 64'(flag_out), 64'b0001);
        flag_in = 4'b0000; step();
        chk("pass_drop", 64'(flag_out), 64'b0000);
        use_flag = 4'b0000; flag_in = 4'b0001; step();
        chk("pass_unused", 64'(flag_out), 64'b0000);

        // Sticky with ack ordering
        mode_sticky = 1'b1; use_flag = 4'hF; flag_in = 4'b1010; step();
        chk("sticky_set", 64'(flag_out), 64'b1010);
        chk("sticky_cause1", 64'(exc_cause), 64'd1);
        flag_in = 4'b0000; exc_ack = 1'b1; step();
        chk("ack1_flags", 64'(flag_out), 64'b1000);
        chk("ack1_cause", 64'(exc_cause), 64'd3);
        step();
        chk("ack2_flags", 64'(flag_out), 64'b0000);
        chk("ack2_pending", 64'(exc_pending), 64'd0);
        exc_ack = 1'b0;

        // Set beats clear
        flag_in = 4'b0100; step();
        flag_clr = 4'b0100; step();
        chk("set_beats_clr", 64'(flag_out[2]), 64'd1);
        flag_in = 4'b0000; step();
        chk("clr_alone", 64'(flag_out[2]), 64'd0);
        flag_clr = 4'b0000;

        // Counter saturation, held level, clear vs. rise
        count_clr = 1'b1; step(); count_clr = 1'b0;
        use_flag = 4'b0001;
        for (int k = 0; k < 9; k++) begin
            flag_in = 4'b0001; step();
            flag_in = 4'b0000; step();
        end
        chk("cnt_saturate", 64'(event_count[CW-1:0]), 64'd7);
        count_clr = 1'b1; step(); count_clr = 1'b0;
        flag_in = 4'b0001;
        repeat (5) step();
        chk("cnt_held_high", 64'(event_count[CW-1:0]), 64'd1);
        flag_in = 4'b0000; step();
        flag_in = 4'b0001; count_clr = 1'b1; step();
        chk("cnt_clr_wins", 64'(event_count[CW-1:0]), 64'd0);
        count_clr = 1'b0; step();
        chk("cnt_prev_updated", 64'(event_count[CW-1:0]), 64'd0);

        // Ack with nothing pending; ack ignored in pass-through
        flag_in = 4'b0000; flag_clr = 4'hF; step(); flag_clr = 4'h0;
        exc_ack = 1'b1; step();
        chk("ack_idle", 64'(flag_out), 64'd0);
        mode_sticky = 1'b0; use_flag = 4'hF; flag_in = 4'b0010; step();
        chk("pass_ack1", 64'(flag_out), 64'b0010);
        step();
        chk("pass_ack2", 64'(flag_out), 64'b0010);
        exc_ack = 1'b0;

        // Mode switch sticky -> pass discards held flags
        mode_sticky = 1'b1; flag_in = 4'b0101; step();
        mode_sticky = 1'b0; flag_in = 4'b0000; step();
        chk("sticky_to_pass", 64'(flag_out), 64'd0);

        // Asynchronous reset mid-cycle
        mode_sticky = 1'b1; flag_in = 4'hF; step();
        #3 reset = 1'b0;
        #1;
        m_reset();
        chk("async_flags", 64'(flag_out), 64'd0);
        chk("async_count", 64'(event_count), 64'd0);
        chk("async_pending", 64'(exc_pending), 64'd0);
        @(negedge clock);
        #3 reset = 1'b1;
        #1;

        // Randomized run
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) mode_sticky = ~mode_sticky;
            use_flag  = 4'($urandom_range(0, 15) | 32'($urandom_range(0, 1) ? 4'hF : 4'h0));
            flag_in   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            flag_clr  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
            exc_ack   = ($urandom_range(0, 3) == 0);
            count_clr = ($urandom_range(0, 200) == 0);
            step();
        end

        @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/exception_flag_reg.md
Name: exception_flag_reg

Overview:
- Parametrised successor to the single overflow flag register.
- Holds N_CH qualified exception flags (overflow, divide-by-zero, invalid opcode, misalignment, ...) for the multicycle CPU datapath.
- Per-channel enable, selectable pass-through or sticky mode, lowest-index cause encoding with a pending/ack handshake to the control unit, and saturating per-channel event counters for debug.

Parameters:
- N_CH, 4: number of exception channels (1..16).
- CNT_W, 8: width of each per-channel event counter.
- CAUSE_W, 4: width of the cause index; must satisfy 2**CAUSE_W >= N_CH.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- mode_sticky  in  1  0 = pass-through mode, 1 = sticky mode.
- use_flag  in  N_CH  per-channel enable; qualifies flag_in.
- flag_in  in  N_CH  raw exception signals from ALU/datapath.
- flag_clr  in  N_CH  per-channel software clear (sticky mode only).
- exc_ack  in  1  control unit acknowledges the current cause.
- count_clr  in  1  zeroes all event counters.
- flag_out  out  N_CH  registered flags.
- exc_pending  out  1  OR of flag_out.
- exc_cause  out  CAUSE_W  index of lowest set flag_out bit; 0 when none set.
- event_count  out  N_CH*CNT_W  counters, channel i at bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset (reset==0, asynchronous): flag_out=0, all counters=0, edge-history registers=0. Consequently exc_pending=0 and exc_cause=0. Leaving reset: first update occurs on the next rising edge.
- Qualified event q[i] = use_flag[i] & flag_in[i]. Flags have 1-cycle latency: q sampled at edge k appears on flag_out after edge k.
- Pass-through mode: flag_out[i] <= q[i] every cycle. flag_clr and exc_ack are ignored. With use_flag[i]=0, flag_out[i] <= 0 (original overflow-register behaviour).
- Sticky mode: flag_out[i] <= q[i] | (flag_out[i] & ~flag_clr[i] & ~ack_hit[i]). ack_hit[i] = exc_ack & exc_pending & (exc_cause==i).
  - Set beats clear: a simultaneous q[i] with flag_clr[i] or ack_hit[i] leaves the flag at 1, so no event is lost.
- exc_pending and exc_cause are combinational from flag_out only, with no input-to-output path. Priority is fixed: channel 0 highest.
- exc_ack with exc_pending=0 has no effect. One ack clears exactly one channel. The next-lowest set channel becomes the cause the following cycle.
- Mode switch sticky->pass: on the next edge flags take q directly and held values are discarded. pass->sticky: current flags are retained and accumulate from then on.
- Counters:
  - Count rising edges of q[i] (q[i]=1 and q_prev[i]=0), independent of mode.
  - Saturate at 2**CNT_W-1; no wrap.
  - count_clr zeroes all counters and wins over a same-cycle increment (result 0). q_prev still updates.
- No X propagation: unused cause bits drive 0. For N_CH < 2**CAUSE_W, exc_cause never exceeds N_CH-1.

Decomposition:
- Shared package exc_pkg:
  - default N_CH/CNT_W/CAUSE_W;
  - cause index constants CAUSE_OVERFLOW=0, CAUSE_DIV0=1, CAUSE_BAD_OPCODE=2, CAUSE_MISALIGN=3, used by the control unit for EPC/vector selection.
- One sub-module, flag_event_counter: q_prev register, rising-edge detect, saturating CNT_W counter with count_clr. Instantiated N_CH times in a generate loop.
- Cause priority encoder and flag update logic stay in the top module.

Test Plan:
- Async reset: drive flags/counters non-zero, pull reset low mid-cycle -> flag_out=0, event_count=0, exc_pending=0 immediately, without waiting for a clock edge.
- Pass-through: mode_sticky=0, use_flag=4'b0001, flag_in=4'b0011 for one cycle -> flag_out=4'b0001 after that edge, 4'b0000 the edge after; use_flag=0 with flag_in=1 -> flag_out stays 0.
- Sticky plus ack ordering: mode_sticky=1, use_flag=4'hF, pulse flag_in=4'b1010 for one cycle -> flag_out=4'b1010, exc_cause=1. exc_ack -> flag_out=4'b1000, exc_cause=3. exc_ack -> flag_out=0, exc_pending=0.
- Set beats clear: sticky with flag_out[2]=1; same cycle flag_clr[2]=1 and q[2]=1 -> flag_out[2] remains 1. Next cycle flag_clr[2] alone -> 0.
- Counter saturation: CNT_W=3, toggle q[0] 9 times -> event_count[2:0]=7. Holding q[0] high for 5 cycles adds at most one count. count_clr on the same edge as a rising q -> count 0.
- Ack with nothing pending: exc_ack=1 and flag_out=0 -> no state change. In pass-through mode an ack with a flag set -> flag follows q only.
